sd_emmc_axi_wr_master: RTL

- AXI4 master write-channel engine downstream of the eMMC DMA read path; the DMA read path moves card data to system memory.
- Accepts the DMA single-beat write request (address valid/ready, data valid, w_last) plus the FIFO read word.
- Runs the AW/W/B handshakes on the system bus.
- Returns a one-cycle next_data_word pulse per completed write response, with sticky bus error and timeout status.

---
 rtl/sd_emmc_axi_pkg.sv | 29 ++
 rtl/sd_emmc_axi_wr_master.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sd_emmc_axi_pkg.sv
// Shared AXI constants and write-engine state encoding
// for the eMMC DMA system-bus master.
package sd_emmc_axi_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AW     = 3'd1;
  localparam logic [2:0] ST_W_WAIT = 3'd2;
  localparam logic [2:0] ST_W      = 3'd3;
  localparam logic [2:0] ST_B      = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    AW     = ST_AW,
    W_WAIT = ST_W_WAIT,
    W      = ST_W,
    B      = ST_B,
    DONE   = ST_DONE
  } wr_state_t;

endpackage

// File: rtl/sd_emmc_axi_wr_master.sv
// Single-beat AXI4 write engine: runs AW, W and B for each
// DMA request and reports completion and sticky errors.
module sd_emmc_axi_wr_master
  import sd_emmc_axi_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic                addr_write_valid,
  output logic                addr_write_ready,
  input  logic                data_write_valid,
  input  logic                w_last,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                next_data_word,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic                m_axi_wlast,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic                err_clr,
  output logic                bresp_err,
  output logic                timeout_err,
  output logic                unaligned_err
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  wr_state_t         state, state_d;
  logic [ADDR_W-1:0] awaddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              awvalid_d, wvalid_d, wlast_d;
  logic              bready_d, awr_d, ndw_d;
  logic [TO_W-1:0]   to_cnt;
  logic              waiting, to_hit;
  logic              unal_set, bresp_set;

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    awaddr_d  = m_axi_awaddr;
    awvalid_d = m_axi_awvalid;
    wdata_d   = m_axi_wdata;
    wlast_d   = m_axi_wlast;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    awr_d     = 1'b0;
    ndw_d     = 1'b0;
    case (state)
      IDLE: if (addr_write_valid) begin
        awaddr_d  = {write_addr[ADDR_W-1:2], 2'b00};
        awvalid_d = 1'b1;
        state_d   = AW;
      end
      AW: if (m_axi_awready) begin
        awvalid_d = 1'b0;
        awr_d     = 1'b1;
        state_d   = W_WAIT;
      end
      W_WAIT: if (data_write_valid) begin
        wdata_d  = fifo_data;
        wlast_d  = w_last;
        wvalid_d = 1'b1;
        state_d  = W;
      end
      W: if (m_axi_wready) begin
        wvalid_d = 1'b0;
        bready_d = 1'b1;
        state_d  = B;
      end
      B: if (m_axi_bvalid) begin
        bready_d = 1'b0;
        ndw_d    = 1'b1;
        state_d  = DONE;
      end
      // guard cycle absorbs the DMA's late drop of data_write_valid
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_axi_awaddr     <= '0;
      m_axi_awvalid    <= 1'b0;
      m_axi_wdata      <= '0;
      m_axi_wlast      <= 1'b0;
      m_axi_wvalid     <= 1'b0;
      m_axi_bready     <= 1'b0;
      addr_write_ready <= 1'b0;
      next_data_word   <= 1'b0;
    end else begin
      m_axi_awaddr     <= awaddr_d;
      m_axi_awvalid    <= awvalid_d;
      m_axi_wdata      <= wdata_d;
      m_axi_wlast      <= wlast_d;
      m_axi_wvalid     <= wvalid_d;
      m_axi_bready     <= bready_d;
      addr_write_ready <= awr_d;
      next_data_word   <= ndw_d;
    end
  end

  assign waiting = (state == AW) || (state == W) || (state == B);
  assign to_hit  = waiting && (state_d == state) &&
                   (to_cnt == TO_MAX - 1'b1);

  // counter saturates; the FSM keeps waiting since valid cannot drop
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          to_cnt <= '0;
    else if (state_d != state)          to_cnt <= '0;
    else if (waiting && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
  end

  assign unal_set  = (state == IDLE) && addr_write_valid &&
                     (write_addr[1:0] != 2'b00);
  assign bresp_set = (state == B) && m_axi_bvalid &&
                     ((m_axi_bresp == BRESP_SLVERR) ||
                      (m_axi_bresp == BRESP_DECERR));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bresp_err     <= 1'b0;
      timeout_err   <= 1'b0;
      unaligned_err <= 1'b0;
    end else begin
      bresp_err     <= (bresp_err & ~err_clr) | bresp_set;
      timeout_err   <= (timeout_err & ~err_clr) | to_hit;
      unaligned_err <= (unaligned_err & ~err_clr) | unal_set;
    end
  end

endmodule
